// File: rtl/point_tracker_if.sv
// Pixel stream into the colour-blob tracker and the centroid/status signals it returns.
// The master drives pixels (video source); the slave is the tracker.
interface point_tracker_if;
    logic [29:0] i_color;
    logic [9:0]  i_h;
    logic [9:0]  i_v;
    logic        i_rendering;
    logic        i_frame_end;
    logic [9:0]  o_pointH;
    logic [9:0]  o_pointV;
    logic        o_pointVAL;
    logic        o_busy;
    logic        o_drop;

    modport master (
        output i_color, i_h, i_v, i_rendering, i_frame_end,
        input  o_pointH, o_pointV, o_pointVAL, o_busy, o_drop
    );

    modport slave (
        input  i_color, i_h, i_v, i_rendering, i_frame_end,
        output o_pointH, o_pointV, o_pointVAL, o_busy, o_drop
    );
endinterface

// File: rtl/point_tracker.sv
// Red-blob centroid tracker: per-frame coordinate accumulation followed by a
// serial restoring division of the sums by the match count, one quotient bit per cycle.
module point_tracker #(
    parameter int FRAME_W   = 640,
    parameter int FRAME_H   = 480,
    parameter int R_MIN     = 600,
    parameter int GB_MAX    = 300,
    parameter int MIN_COUNT = 64
) (
    input logic            i_clk,
    input logic            i_rst_n,
    point_tracker_if.slave pt
);
    localparam logic [9:0]  FW    = 10'(FRAME_W);
    localparam logic [9:0]  FH    = 10'(FRAME_H);
    localparam logic [9:0]  RMIN  = 10'(R_MIN);
    localparam logic [9:0]  GBMAX = 10'(GB_MAX);
    localparam logic [18:0] MINC  = 19'(MIN_COUNT);

    typedef enum logic [1:0] {IDLE, DIV_H, DIV_V, OUT} state_t;

    state_t      state;
    logic [4:0]  bit_idx;
    logic        match;
    logic [28:0] sum_h, sum_v, sum_h_nxt, sum_v_nxt;
    logic [18:0] cnt, cnt_nxt;
    logic [28:0] num;
    logic [28:0] op_v;
    logic [18:0] den, rem;
    logic [9:0]  q_h;
    logic [19:0] step;

    // One restoring step: returns {next remainder, quotient bit}. The remainder
    // stays below the divisor, so 19 bits hold it and the trial needs only one more.
    function automatic logic [19:0] div_step(input logic [18:0] r, input logic msb,
                                             input logic [18:0] d);
        logic [19:0] trial;
        logic [18:0] diff;
        trial = {r, msb};
        diff  = trial[18:0] - d;
        if (trial >= {1'b0, d}) div_step = {diff, 1'b1};
        else                    div_step = {trial[18:0], 1'b0};
    endfunction

    always_comb begin
        match = pt.i_rendering && (pt.i_h < FW) && (pt.i_v < FH) &&
                (pt.i_color[29:20] >= RMIN) &&
                (pt.i_color[19:10] <= GBMAX) && (pt.i_color[9:0] <= GBMAX);
        sum_h_nxt = sum_h + (match ? {19'd0, pt.i_h} : 29'd0);
        sum_v_nxt = sum_v + (match ? {19'd0, pt.i_v} : 29'd0);
        cnt_nxt   = cnt + {18'd0, match};
        step      = div_step(rem, num[28], den);
    end

    // Accumulation never stalls; a frame end always starts a fresh frame.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sum_h <= '0;
            sum_v <= '0;
            cnt   <= '0;
        end else if (pt.i_frame_end) begin
            sum_h <= '0;
            sum_v <= '0;
            cnt   <= '0;
        end else begin
            sum_h <= sum_h_nxt;
            sum_v <= sum_v_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Divider datapath: quotient bits shift into num's LSB as the dividend leaves its MSB.
    always_ff @(posedge i_clk) begin
        case (state)
            IDLE: begin
                if (pt.i_frame_end) begin
                    num  <= sum_h_nxt;
                    op_v <= sum_v_nxt;
                    den  <= cnt_nxt;
                    rem  <= '0;
                end
            end
            DIV_H: begin
                if (bit_idx == 5'd0) begin
                    q_h <= {num[8:0], step[0]};
                    num <= op_v;
                    rem <= '0;
                end else begin
                    num <= {num[27:0], step[0]};
                    rem <= step[19:1];
                end
            end
            DIV_V: begin
                num <= {num[27:0], step[0]};
                rem <= step[19:1];
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state         <= IDLE;
            bit_idx       <= '0;
            pt.o_pointH   <= 10'h3FF;
            pt.o_pointV   <= 10'h3FF;
            pt.o_pointVAL <= 1'b0;
            pt.o_busy     <= 1'b0;
            pt.o_drop     <= 1'b0;
        end else begin
            pt.o_pointVAL <= 1'b0;
            pt.o_drop     <= pt.i_frame_end && pt.o_busy;
            case (state)
                IDLE: begin
                    if (pt.i_frame_end) begin
                        state     <= DIV_H;
                        bit_idx   <= 5'd28;
                        pt.o_busy <= 1'b1;
                    end
                end
                DIV_H: begin
                    if (bit_idx == 5'd0) begin
                        state   <= DIV_V;
                        bit_idx <= 5'd28;
                    end else begin
                        bit_idx <= bit_idx - 5'd1;
                    end
                end
                DIV_V: begin
                    if (bit_idx == 5'd0) state <= OUT;
                    else                 bit_idx <= bit_idx - 5'd1;
                end
                OUT: begin
                    state     <= IDLE;
                    pt.o_busy <= 1'b0;
                    // Too few pixels means noise; keep the last good point on screen.
                    if (den >= MINC) begin
                        pt.o_pointH   <= q_h;
                        pt.o_pointV   <= num[9:0];
                        pt.o_pointVAL <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_point_tracker.sv
// Randomized bench for point_tracker with a frame-level centroid reference model.
module tb_point_tracker;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    point_tracker_if pif();
    point_tracker dut (.i_clk(clk), .i_rst_n(rst_n), .pt(pif));

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         val_cyc[$];
    logic [9:0] val_h[$];
    logic [9:0] val_v[$];
    int         drop_cyc[$];
    always @(negedge clk) begin
        if (pif.o_pointVAL === 1'b1) begin
            val_cyc.push_back(cyc);
            val_h.push_back(pif.o_pointH);
            val_v.push_back(pif.o_pointV);
        end
        if (pif.o_drop === 1'b1) drop_cyc.push_back(cyc);
    end

    // Reference model: running sums of the current frame and the result of the last closed one.
    longint m_sh, m_sv, m_cnt;
    longint e_cnt, e_h, e_v;
    int     fe_edge;

    function automatic bit is_match(logic [29:0] c, int h, int v, bit r);
        logic [9:0] rr, gg, bb;
        rr = c[29:20]; gg = c[19:10]; bb = c[9:0];
        return r && h < 640 && v < 480 && rr >= 600 && gg <= 300 && bb <= 300;
    endfunction

    function automatic logic [29:0] col_match();
        logic [9:0] rr, gg, bb;
        rr = 10'($urandom_range(600, 1023));
        gg = 10'($urandom_range(0, 300));
        bb = 10'($urandom_range(0, 300));
        return {rr, gg, bb};
    endfunction

    function automatic logic [29:0] col_nomatch();
        logic [9:0] rr, gg, bb;
        rr = 10'($urandom_range(0, 599));
        gg = 10'($urandom_range(0, 1023));
        bb = 10'($urandom_range(0, 1023));
        return {rr, gg, bb};
    endfunction

    function automatic logic [29:0] col_edge();
        logic [9:0] rr, gg, bb;
        rr = 10'($urandom_range(595, 605));
        gg = 10'($urandom_range(295, 305));
        bb = 10'($urandom_range(295, 305));
        return {rr, gg, bb};
    endfunction

    function automatic void model_clear();
        m_sh = 0; m_sv = 0; m_cnt = 0;
    endfunction

    task automatic drive(input logic [29:0] c, input int h, input int v, input bit r, input bit fe);
        @(negedge clk);
        pif.i_color = c; pif.i_h = h[9:0]; pif.i_v = v[9:0];
        pif.i_rendering = r; pif.i_frame_end = fe;
        if (is_match(c, h, v, r)) begin
            m_sh += h; m_sv += v; m_cnt++;
        end
        if (fe) begin
            fe_edge = cyc + 1;
            e_cnt = m_cnt;
            e_h = (m_cnt != 0) ? m_sh / m_cnt : 0;
            e_v = (m_cnt != 0) ? m_sv / m_cnt : 0;
            model_clear();
        end
    endtask

    task automatic idle(input int n);
        repeat (n) drive(col_nomatch(), $urandom_range(0, 1023), $urandom_range(0, 1023),
                         1'($urandom_range(0, 1)), 1'b0);
    endtask

    // 8x8 blob; bad pixel gets G=400. Each row also carries one decoy pixel.
    task automatic drive_blob(input int h0, input int v0, input int bad_h, input int bad_v,
                              input bit hard_decoys);
        logic [29:0] c;
        int sel;
        for (int v = v0; v < v0 + 8; v++) begin
            for (int h = h0; h < h0 + 8; h++) begin
                c = col_match();
                if (h == bad_h && v == bad_v) c[19:10] = 10'd400;
                drive(c, h, v, 1'b1, 1'b0);
            end
            sel = $urandom_range(0, 2);
            if (!hard_decoys)  drive(col_nomatch(), $urandom_range(0, 639), $urandom_range(0, 479), 1'b1, 1'b0);
            else if (sel == 0) drive(col_match(), 700, v, 1'b1, 1'b0);
            else if (sel == 1) drive(col_match(), $urandom_range(0, 639), $urandom_range(0, 479), 1'b0, 1'b0);
            else               drive(col_match(), $urandom_range(0, 639), $urandom_range(480, 1023), 1'b1, 1'b0);
        end
    endtask

    function automatic void clear_events();
        val_cyc.delete(); val_h.delete(); val_v.delete(); drop_cyc.delete();
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        pif.i_color = '0; pif.i_h = '0; pif.i_v = '0; pif.i_rendering = 1'b0; pif.i_frame_end = 1'b0;
        model_clear();
        repeat (3) @(negedge clk);
        checks++; if (pif.o_pointH !== 10'h3FF) begin errors++; $display("FAIL reset_pointH: got %h expected 3ff", pif.o_pointH); end
        checks++; if (pif.o_pointV !== 10'h3FF) begin errors++; $display("FAIL reset_pointV: got %h expected 3ff", pif.o_pointV); end
        checks++; if (pif.o_pointVAL !== 1'b0) begin errors++; $display("FAIL reset_val: got %b expected 0", pif.o_pointVAL); end
        checks++; if (pif.o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", pif.o_busy); end
        checks++; if (pif.o_drop !== 1'b0) begin errors++; $display("FAIL reset_drop: got %b expected 0", pif.o_drop); end
        rst_n = 1'b1;
    endtask

    task automatic test_below_min();
        clear_events();
        drive_blob(100, 200, 103, 204, 1'b0);
        drive(col_nomatch(), 0, 0, 1'b0, 1'b1);
        idle(30);
        checks++; if (pif.o_busy !== 1'b1) begin errors++; $display("FAIL busy_mid: got %b expected 1", pif.o_busy); end
        idle(40);
        checks++; if (pif.o_busy !== 1'b0) begin errors++; $display("FAIL busy_after: got %b expected 0", pif.o_busy); end
        checks++; if (val_cyc.size() !== ((e_cnt >= 64) ? 1 : 0)) begin errors++; $display("FAIL below_min_pulses: got %0d expected %0d", val_cyc.size(), (e_cnt >= 64) ? 1 : 0); end
        checks++; if (pif.o_pointH !== 10'h3FF) begin errors++; $display("FAIL below_min_H: got %0d expected 1023", pif.o_pointH); end
        checks++; if (pif.o_pointV !== 10'h3FF) begin errors++; $display("FAIL below_min_V: got %0d expected 1023", pif.o_pointV); end
    endtask

    task automatic test_min_boundary();
        clear_events();
        drive_blob(100, 200, 103, 204, 1'b0);
        drive(col_match(), 103, 204, 1'b1, 1'b1);
        idle(70);
        checks++;
        if (val_cyc.size() !== 1) begin errors++; $display("FAIL min_boundary_pulses: got %0d expected 1", val_cyc.size()); end
        else begin
            checks++; if (val_cyc[0] !== fe_edge + 59) begin errors++; $display("FAIL min_boundary_latency: got %0d expected %0d", val_cyc[0] - fe_edge, 59); end
            checks++; if (val_h[0] !== 10'(e_h) || val_h[0] !== 10'd103) begin errors++; $display("FAIL min_boundary_H: got %0d expected %0d", val_h[0], e_h); end
            checks++; if (val_v[0] !== 10'(e_v) || val_v[0] !== 10'd203) begin errors++; $display("FAIL min_boundary_V: got %0d expected %0d", val_v[0], e_v); end
        end
    endtask

    task automatic test_blob(input bit hard_decoys, input string name);
        clear_events();
        idle($urandom_range(1, 20));
        drive_blob(100, 200, -1, -1, hard_decoys);
        idle($urandom_range(0, 5));
        drive(col_nomatch(), 0, 0, 1'b1, 1'b1);
        idle(70);
        checks++;
        if (val_cyc.size() !== 1) begin errors++; $display("FAIL %s_pulses: got %0d expected 1", name, val_cyc.size()); end
        else begin
            checks++; if (val_cyc[0] !== fe_edge + 59) begin errors++; $display("FAIL %s_latency: got %0d expected 59", name, val_cyc[0] - fe_edge); end
            checks++; if (val_h[0] !== 10'(e_h) || val_h[0] !== 10'd103) begin errors++; $display("FAIL %s_H: got %0d expected 103", name, val_h[0]); end
            checks++; if (val_v[0] !== 10'(e_v) || val_v[0] !== 10'd203) begin errors++; $display("FAIL %s_V: got %0d expected 203", name, val_v[0]); end
        end
    endtask

    task automatic test_large();
        logic [29:0] c;
        clear_events();
        for (int v = 0; v < 480; v++)
            for (int h = 600; h < 640; h++) begin
                c = ($urandom_range(0, 3) != 0) ? col_match() : col_edge();
                drive(c, h, v, 1'b1, 1'b0);
            end
        drive(col_match(), 639, 479, 1'b1, 1'b1);
        idle(70);
        checks++;
        if (val_cyc.size() !== 1) begin errors++; $display("FAIL large_pulses: got %0d expected 1", val_cyc.size()); end
        else begin
            checks++; if (val_h[0] !== 10'(e_h)) begin errors++; $display("FAIL large_H: got %0d expected %0d", val_h[0], e_h); end
            checks++; if (val_v[0] !== 10'(e_v)) begin errors++; $display("FAIL large_V: got %0d expected %0d", val_v[0], e_v); end
        end
    endtask

    task automatic test_overlap();
        int fe_a, fe2, fe_b;
        longint a_h, a_v, b_h, b_v;
        clear_events();
        drive_blob($urandom_range(0, 632), $urandom_range(0, 472), -1, -1, 1'b0);
        drive(col_nomatch(), 0, 0, 1'b0, 1'b1);
        fe_a = fe_edge; a_h = e_h; a_v = e_v;
        for (int i = 0; i < 19; i++) drive(col_match(), $urandom_range(0, 639), $urandom_range(0, 479), 1'b1, 1'b0);
        drive(col_match(), 10, 10, 1'b1, 1'b1);
        fe2 = fe_edge;
        idle(60);
        drive_blob($urandom_range(0, 632), $urandom_range(0, 472), -1, -1, 1'b1);
        drive(col_nomatch(), 0, 0, 1'b0, 1'b1);
        fe_b = fe_edge; b_h = e_h; b_v = e_v;
        idle(70);
        checks++;
        if (drop_cyc.size() !== 1) begin errors++; $display("FAIL overlap_drops: got %0d expected 1", drop_cyc.size()); end
        else begin
            checks++; if (drop_cyc[0] !== fe2) begin errors++; $display("FAIL overlap_drop_cycle: got %0d expected %0d", drop_cyc[0], fe2); end
        end
        checks++;
        if (val_cyc.size() !== 2) begin errors++; $display("FAIL overlap_pulses: got %0d expected 2", val_cyc.size()); end
        else begin
            checks++; if (val_cyc[0] !== fe_a + 59) begin errors++; $display("FAIL overlap_a_latency: got %0d expected 59", val_cyc[0] - fe_a); end
            checks++; if (val_h[0] !== 10'(a_h) || val_v[0] !== 10'(a_v)) begin errors++; $display("FAIL overlap_a_point: got %0d,%0d expected %0d,%0d", val_h[0], val_v[0], a_h, a_v); end
            checks++; if (val_cyc[1] !== fe_b + 59) begin errors++; $display("FAIL overlap_b_latency: got %0d expected 59", val_cyc[1] - fe_b); end
            checks++; if (val_h[1] !== 10'(b_h) || val_v[1] !== 10'(b_v)) begin errors++; $display("FAIL overlap_b_point: got %0d,%0d expected %0d,%0d", val_h[1], val_v[1], b_h, b_v); end
        end
    endtask

    task automatic test_reset_mid();
        clear_events();
        drive_blob($urandom_range(0, 632), $urandom_range(0, 472), -1, -1, 1'b0);
        drive(col_nomatch(), 0, 0, 1'b0, 1'b1);
        idle(40);
        #2 rst_n = 1'b0;
        model_clear();
        #1;
        checks++; if (pif.o_pointH !== 10'h3FF || pif.o_pointV !== 10'h3FF) begin errors++; $display("FAIL reset_mid_point: got %h,%h expected 3ff,3ff", pif.o_pointH, pif.o_pointV); end
        checks++; if (pif.o_busy !== 1'b0) begin errors++; $display("FAIL reset_mid_busy: got %b expected 0", pif.o_busy); end
        @(negedge clk);
        rst_n = 1'b1;
        idle(80);
        checks++; if (val_cyc.size() !== 0) begin errors++; $display("FAIL reset_mid_pulses: got %0d expected 0", val_cyc.size()); end
        drive_blob($urandom_range(0, 632), $urandom_range(0, 472), -1, -1, 1'b1);
        drive(col_nomatch(), 0, 0, 1'b0, 1'b1);
        idle(70);
        checks++;
        if (val_cyc.size() !== 1) begin errors++; $display("FAIL after_reset_pulses: got %0d expected 1", val_cyc.size()); end
        else begin
            checks++; if (val_h[0] !== 10'(e_h) || val_v[0] !== 10'(e_v)) begin errors++; $display("FAIL after_reset_point: got %0d,%0d expected %0d,%0d", val_h[0], val_v[0], e_h, e_v); end
        end
    endtask

    initial begin
        test_reset();
        test_below_min();
        test_min_boundary();
        test_blob(1'b0, "blob");
        test_blob(1'b1, "mixed");
        test_large();
        test_overlap();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/point_tracker.md
Name: point_tracker

Overview:
- Colour-blob tracker directly upstream of the trajectory overlay stage.
- Each frame, it accumulates the coordinates of every active pixel whose 30-bit colour passes a red-dominance threshold.
- At frame end it computes the integer centroid with a serial restoring divider.
- It presents the centroid on o_pointH/o_pointV with a one-cycle o_pointVAL pulse, which the overlay consumes as i_pointH/i_pointV/i_pointVAL.

Parameters:
- FRAME_W, 640, active columns; pixels with i_h >= FRAME_W are ignored.
- FRAME_H, 480, active rows; pixels with i_v >= FRAME_H are ignored.
- R_MIN, 600, minimum red component for a match.
- GB_MAX, 300, maximum green and blue components for a match.
- MIN_COUNT, 64, minimum matched-pixel count for a valid centroid.

Ports:
- i_clk  in  1  pixel clock
- i_rst_n  in  1  asynchronous active-low reset
- i_color  in  30  pixel colour {R[29:20], G[19:10], B[9:0]}
- i_h  in  10  pixel column
- i_v  in  10  pixel row
- i_rendering  in  1  pixel qualifier; high when i_color/i_h/i_v is an active pixel
- i_frame_end  in  1  single-cycle pulse after the last active pixel of a frame
- o_pointH  out  10  centroid column
- o_pointV  out  10  centroid row
- o_pointVAL  out  1  one-cycle pulse; the centroid is new
- o_busy  out  1  high while a division is in progress
- o_drop  out  1  one-cycle pulse; a frame result was discarded

Behaviour:
- Reset is asynchronous and active-low, on i_rst_n; the clock is i_clk.
- Reset values:
  - o_pointH = o_pointV = 10'h3FF (no point).
  - o_pointVAL = 0, o_busy = 0, o_drop = 0.
  - Accumulators and count = 0; FSM = IDLE.
- Match condition: i_rendering && i_h < FRAME_W && i_v < FRAME_H && R >= R_MIN && G <= GB_MAX && B <= GB_MAX.
- Accumulators (all unsigned):
  - sumH, 29 bits: += i_h on each match.
  - sumV, 29 bits: += i_v on each match.
  - cnt, 19 bits: += 1 on each match.
  - Widths cover a full 640x480 frame without overflow.
- Accumulation runs in every FSM state, so the next frame is collected while the current one is divided.
- On an edge sampling i_frame_end = 1:
  - A match on that same cycle is included in the closing frame.
  - sumH/sumV/cnt are copied into the divider operand registers, then the accumulators clear to 0.
- FSM states:
  - IDLE: on i_frame_end, latch operands and go to DIV_H.
  - DIV_H: restoring division sumH/cnt, one quotient bit per cycle, 29 cycles, MSB first; then go to DIV_V.
  - DIV_V: same for sumV/cnt, 29 cycles; then go to OUT.
  - OUT: one cycle, then back to IDLE.
- Output timing:
  - In OUT, if the latched cnt >= MIN_COUNT, o_pointH/o_pointV load the quotients' low 10 bits and o_pointVAL = 1.
  - Otherwise o_pointH/o_pointV hold their values and o_pointVAL stays 0.
  - o_pointVAL is high for exactly one cycle, starting 59 cycles after the edge that samples i_frame_end.
  - Latency is fixed and independent of the data.
- Quotients are floor values. Because only in-frame pixels are counted, the quotient is always < FRAME_W (resp. FRAME_H).
- cnt = 0: the divider runs normally and the result is suppressed by the MIN_COUNT check; no special path.
- o_busy = 1 in DIV_H, DIV_V and OUT.
- Overlap: i_frame_end while o_busy = 1:
  - The accumulators still clear, so the new frame's data is discarded.
  - The in-progress division continues unaffected.
  - o_drop pulses for one cycle on the following cycle.
- The block has no backpressure; the downstream stage samples o_pointVAL unconditionally.
- Reset mid-operation returns everything to reset values immediately; no pulse is issued for the interrupted frame.

Test Plan:
- 8x8 matching blob at h 100..107, v 200..207 (R=1023, G=B=0), background black, then i_frame_end -> exactly one o_pointVAL pulse 59 cycles after frame_end, with o_pointH=103, o_pointV=203.
- Same blob with one pixel changed to G=400 (63 matches) -> no o_pointVAL pulse; o_pointH/o_pointV remain 10'h3FF.
- Full frame of matching pixels -> o_pointH=319, o_pointV=239; no accumulator overflow.
- Matching pixels at i_h=700 or i_rendering=0 mixed with the blob from the first scenario -> result unchanged (103, 203).
- Second i_frame_end 20 cycles after the first -> o_drop pulse one cycle later; first result still delivered at +59; the next full frame reports correctly.
- i_rst_n asserted during DIV_V -> outputs return to reset values immediately; no o_pointVAL pulse; the next frame after reset reports correctly.
